// File: rtl/aoc3_pkg.sv
// Shared types and defaults for the day-3 max-subsequence selector.
package aoc3_pkg;

  // Selector FSM: collect digits, stream the kept digits out, then publish the result.
  typedef enum logic [1:0] {
    FILL,
    DRAIN,
    DONE
  } sel_state_e;

  localparam int unsigned DEFAULT_DATA_WIDTH = 4;
  localparam int unsigned DEFAULT_KEEP       = 12;
  localparam int unsigned DEFAULT_RADIX      = 10;

endpackage

// File: rtl/max_subseq_select_if.sv
// Digit-stream in, drained-digit stream out, plus result and status.
interface max_subseq_select_if #(
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned KEEP         = 12,
  parameter int unsigned MAX_LEN      = 128,
  parameter int unsigned RESULT_WIDTH = 64
);
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_LEN + 1);
  localparam int unsigned SIZE_WIDTH = $clog2(KEEP) + 1;

  logic [LEN_WIDTH-1:0]    line_len;
  logic                    in_valid;
  logic                    in_ready;
  logic [DATA_WIDTH-1:0]   in_data;
  logic                    in_last;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_last;
  logic [RESULT_WIDTH-1:0] result;
  logic                    result_valid;
  logic [SIZE_WIDTH-1:0]   size;

  // Upstream/downstream side.
  modport master (
    output line_len, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, result, result_valid, size
  );

  // Selector side.
  modport slave (
    input  line_len, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, result, result_valid, size
  );
endinterface

// File: rtl/max_subseq_select_stack_regfile.sv
// KEEP-deep digit stack with push/pop at the top and an indexed read port for draining.
module stack_regfile #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned KEEP       = 12
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      clear,
  input  logic [DATA_WIDTH-1:0]     push_data,
  output logic [DATA_WIDTH-1:0]     top,
  input  logic [$clog2(KEEP):0]     rd_idx,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic [$clog2(KEEP):0]     size
);
  localparam int unsigned SIZE_WIDTH = $clog2(KEEP) + 1;
  localparam int unsigned IDX_WIDTH  = (KEEP > 1) ? $clog2(KEEP) : 1;

  logic [DATA_WIDTH-1:0] mem_q [KEEP];
  logic [SIZE_WIDTH-1:0] size_q;
  logic [SIZE_WIDTH-1:0] top_pos;

  assign top_pos = size_q - SIZE_WIDTH'(1);
  assign top     = mem_q[top_pos[IDX_WIDTH-1:0]];
  assign rd_data = mem_q[rd_idx[IDX_WIDTH-1:0]];
  assign size    = size_q;

  // Stack storage and occupancy; clear takes priority so a finished line never leaks.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      size_q <= '0;
      for (int i = 0; i < KEEP; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clear) begin
      size_q <= '0;
    end else if (push) begin
      mem_q[size_q[IDX_WIDTH-1:0]] <= push_data;
      size_q                       <= size_q + SIZE_WIDTH'(1);
    end else if (pop) begin
      size_q <= size_q - SIZE_WIDTH'(1);
    end
  end
endmodule

// File: rtl/max_subseq_select.sv
// Keeps the lexicographically largest KEEP-digit subsequence of a line, then drains it
// bottom-first while accumulating its base-RADIX value.
module max_subseq_select
  import aoc3_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int unsigned KEEP         = DEFAULT_KEEP,
  parameter int unsigned MAX_LEN      = 128,
  parameter int unsigned RADIX        = DEFAULT_RADIX,
  parameter int unsigned RESULT_WIDTH = 64
) (
  input logic                clock,
  input logic                reset_n,
  max_subseq_select_if.slave bus
);
  localparam int unsigned LEN_WIDTH  = $clog2(MAX_LEN + 1);
  localparam int unsigned SIZE_WIDTH = $clog2(KEEP) + 1;
  localparam logic [LEN_WIDTH-1:0]  KEEP_LEN  = LEN_WIDTH'(KEEP);
  localparam logic [SIZE_WIDTH-1:0] KEEP_SIZE = SIZE_WIDTH'(KEEP);

  sel_state_e              state_q, state_d;
  logic [LEN_WIDTH-1:0]    drops_q, drops_d, drops_eff;
  logic                    first_q, first_d;
  logic [RESULT_WIDTH-1:0] result_q, result_d;
  logic [SIZE_WIDTH-1:0]   idx_q, idx_d;

  logic                    push, pop, clear, last;
  logic [DATA_WIDTH-1:0]   top, rd_data;
  logic [SIZE_WIDTH-1:0]   size;

  stack_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP       (KEEP)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (bus.in_data),
    .top       (top),
    .rd_idx    (idx_q),
    .rd_data   (rd_data),
    .size      (size)
  );

  assign bus.result = result_q;
  assign bus.size   = size;

  // FSM state, drop budget, first-beat flag, drain index and result accumulator.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= FILL;
      drops_q  <= '0;
      first_q  <= 1'b1;
      result_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      drops_q  <= drops_d;
      first_q  <= first_d;
      result_q <= result_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state, stack control and handshake outputs.
  always_comb begin
    state_d  = state_q;
    drops_d  = drops_q;
    first_d  = first_q;
    result_d = result_q;
    idx_d    = idx_q;
    push     = 1'b0;
    pop      = 1'b0;
    clear    = 1'b0;
    last     = 1'b0;
    bus.in_ready     = 1'b0;
    bus.out_valid    = 1'b0;
    bus.out_last     = 1'b0;
    bus.result_valid = 1'b0;
    bus.out_data     = rd_data;

    // On the first beat the budget is loaded from line_len and used in the same cycle.
    drops_eff = drops_q;
    if (first_q) begin
      drops_eff = (bus.line_len > KEEP_LEN) ? bus.line_len - KEEP_LEN : '0;
    end

    unique case (state_q)
      FILL: begin
        if (bus.in_valid) begin
          if ((size != '0) && (top < bus.in_data) && (drops_eff != '0)) begin
            // Beat stays pending; one pop per cycle until it no longer beats the top.
            pop     = 1'b1;
            drops_d = drops_eff - LEN_WIDTH'(1);
          end else begin
            bus.in_ready = 1'b1;
            first_d      = 1'b0;
            if (first_q) begin
              result_d = '0;
            end
            if (size < KEEP_SIZE) begin
              push    = 1'b1;
              drops_d = drops_eff;
            end else begin
              drops_d = (drops_eff != '0) ? drops_eff - LEN_WIDTH'(1) : '0;
            end
            if (bus.in_last) begin
              state_d = DRAIN;
              idx_d   = '0;
            end
          end
        end
      end
      DRAIN: begin
        last          = (idx_q == size - SIZE_WIDTH'(1));
        bus.out_valid = 1'b1;
        bus.out_last  = last;
        if (bus.out_ready) begin
          result_d = result_q * RESULT_WIDTH'(RADIX) + RESULT_WIDTH'(rd_data);
          idx_d    = idx_q + SIZE_WIDTH'(1);
          if (last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        bus.result_valid = 1'b1;
        clear            = 1'b1;
        first_d          = 1'b1;
        state_d          = FILL;
      end
      default: state_d = FILL;
    endcase
  end
endmodule
